// File: rtl/cl_axi_rr_mux_if.sv
// AXI4 signal bundle for cl_axi_rr_mux, replicated N times as packed arrays.
// The upstream side uses N = NUM_MST with the master ID width. The downstream
// side uses N = 1 with the ID width widened by two bits.
// Modports:
//   master - drives AW/W/AR payload+valid, B/R ready; receives the rest
//   slave  - the mirror image
interface cl_axi_rr_mux_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned DW = 512,
  parameter int unsigned IW = 7
);
  logic [N-1:0][IW-1:0]   awid;
  logic [N-1:0][63:0]     awaddr;
  logic [N-1:0][7:0]      awlen;
  logic [N-1:0][2:0]      awsize;
  logic [N-1:0]           awvalid;
  logic [N-1:0]           awready;

  logic [N-1:0][DW-1:0]   wdata;
  logic [N-1:0][DW/8-1:0] wstrb;
  logic [N-1:0]           wlast;
  logic [N-1:0]           wvalid;
  logic [N-1:0]           wready;

  logic [N-1:0][IW-1:0]   bid;
  logic [N-1:0][1:0]      bresp;
  logic [N-1:0]           bvalid;
  logic [N-1:0]           bready;

  logic [N-1:0][IW-1:0]   arid;
  logic [N-1:0][63:0]     araddr;
  logic [N-1:0][7:0]      arlen;
  logic [N-1:0][2:0]      arsize;
  logic [N-1:0]           arvalid;
  logic [N-1:0]           arready;

  logic [N-1:0][IW-1:0]   rid;
  logic [N-1:0][DW-1:0]   rdata;
  logic [N-1:0][1:0]      rresp;
  logic [N-1:0]           rlast;
  logic [N-1:0]           rvalid;
  logic [N-1:0]           rready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/cl_axi_rr_mux.sv
// N:1 AXI4 multiplexer with independent round-robin arbitration on AW and AR.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   i_mst_en         - per-master arbitration enable mask
//   o_err_unmapped   - sticky: a B/R response carried a master index >= NUM_MST
//   s_if (slave)     - NUM_MST upstream AXI4 ports
//   m_if (master)    - single downstream AXI4 port, ID = {master index, upstream ID}
// W beats follow AW grant order through a small FIFO of winner indices.
// B/R responses are routed back by the top two ID bits.
module cl_axi_rr_mux #(
  parameter int unsigned NUM_MST       = 3,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned S_ID_WIDTH    = 7,
  parameter int unsigned WR_FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_MST-1:0] i_mst_en,
  output logic               o_err_unmapped,
  cl_axi_rr_mux_if.slave     s_if,
  cl_axi_rr_mux_if.master    m_if
);
  localparam int unsigned MW     = S_ID_WIDTH + 2;
  localparam int unsigned FifoAw = $clog2(WR_FIFO_DEPTH);

  // Returns {found, index}; the search starts one past the last winner.
  function automatic logic [2:0] rr_pick(input logic [NUM_MST-1:0] req, input logic [1:0] last);
    logic [2:0] res;
    int         idx;
    res = '0;
    for (int k = 1; k <= int'(NUM_MST); k++) begin
      idx = int'(last) + k;
      if (idx >= int'(NUM_MST)) idx = idx - int'(NUM_MST);
      if (!res[2] && req[idx]) res = {1'b1, 2'(idx)};
    end
    return res;
  endfunction

  // ---------------- write-order FIFO ----------------
  logic [1:0]        r_fifo_mem [WR_FIFO_DEPTH];
  logic [FifoAw-1:0] r_fifo_wp, r_fifo_rp;
  logic [FifoAw:0]   r_fifo_cnt;
  logic              w_fifo_full, w_fifo_empty, w_fifo_pop;
  logic [1:0]        w_fifo_head;

  assign w_fifo_full  = (r_fifo_cnt == (FifoAw+1)'(WR_FIFO_DEPTH));
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_fifo_head  = r_fifo_mem[r_fifo_rp];
  assign w_fifo_pop   = m_if.wvalid[0] & m_if.wready[0] & m_if.wlast[0];

  // ---------------- AW arbitration + slice ----------------
  logic [NUM_MST-1:0]    w_aw_req;
  logic                  w_aw_found, w_aw_hs;
  logic [1:0]            w_aw_idx, r_aw_ptr;
  logic [S_ID_WIDTH-1:0] w_aw_id;
  logic [63:0]           w_aw_addr, r_aw_addr;
  logic [7:0]            w_aw_len, r_aw_len;
  logic [2:0]            w_aw_size, r_aw_size;
  logic                  r_aw_vld;
  logic [MW-1:0]         r_aw_id;

  always_comb begin
    // A full FIFO removes every AW request, so a push can never overflow it.
    w_aw_req = s_if.awvalid & i_mst_en & {NUM_MST{~w_fifo_full}};
    {w_aw_found, w_aw_idx} = rr_pick(w_aw_req, r_aw_ptr);
    w_aw_hs      = rst_n & w_aw_found & (~r_aw_vld | m_if.awready[0]);
    s_if.awready = '0;
    w_aw_id      = '0;
    w_aw_addr    = '0;
    w_aw_len     = '0;
    w_aw_size    = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      if (w_aw_idx == 2'(i)) begin
        s_if.awready[i] = w_aw_hs;
        w_aw_id         = s_if.awid[i];
        w_aw_addr       = s_if.awaddr[i];
        w_aw_len        = s_if.awlen[i];
        w_aw_size       = s_if.awsize[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_vld  <= 1'b0;
      r_aw_ptr  <= 2'(NUM_MST - 1);
      r_aw_id   <= '0;
      r_aw_addr <= '0;
      r_aw_len  <= '0;
      r_aw_size <= '0;
    end else if (w_aw_hs) begin
      r_aw_vld  <= 1'b1;
      r_aw_ptr  <= w_aw_idx;
      r_aw_id   <= {w_aw_idx, w_aw_id};
      r_aw_addr <= w_aw_addr;
      r_aw_len  <= w_aw_len;
      r_aw_size <= w_aw_size;
    end else if (m_if.awready[0]) begin
      r_aw_vld  <= 1'b0;
    end
  end

  assign m_if.awvalid[0] = r_aw_vld;
  assign m_if.awid[0]    = r_aw_id;
  assign m_if.awaddr[0]  = r_aw_addr;
  assign m_if.awlen[0]   = r_aw_len;
  assign m_if.awsize[0]  = r_aw_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_wp  <= '0;
      r_fifo_rp  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_aw_hs)    r_fifo_wp <= r_fifo_wp + 1'b1;
      if (w_fifo_pop) r_fifo_rp <= r_fifo_rp + 1'b1;
      case ({w_aw_hs, w_fifo_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_fifo_mem[r_fifo_wp] <= w_aw_idx;
  end

  // ---------------- W steering by FIFO head ----------------
  always_comb begin
    s_if.wready = '0;
    m_if.wdata  = '0;
    m_if.wstrb  = '0;
    m_if.wlast  = '0;
    m_if.wvalid = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      if (!w_fifo_empty && w_fifo_head == 2'(i)) begin
        m_if.wdata[0]  = s_if.wdata[i];
        m_if.wstrb[0]  = s_if.wstrb[i];
        m_if.wlast[0]  = s_if.wlast[i];
        m_if.wvalid[0] = s_if.wvalid[i];
        s_if.wready[i] = m_if.wready[0];
      end
    end
  end

  // ---------------- AR arbitration + slice ----------------
  logic [NUM_MST-1:0]    w_ar_req;
  logic                  w_ar_found, w_ar_hs;
  logic [1:0]            w_ar_idx, r_ar_ptr;
  logic [S_ID_WIDTH-1:0] w_ar_id;
  logic [63:0]           w_ar_addr, r_ar_addr;
  logic [7:0]            w_ar_len, r_ar_len;
  logic [2:0]            w_ar_size, r_ar_size;
  logic                  r_ar_vld;
  logic [MW-1:0]         r_ar_id;

  always_comb begin
    w_ar_req = s_if.arvalid & i_mst_en;
    {w_ar_found, w_ar_idx} = rr_pick(w_ar_req, r_ar_ptr);
    w_ar_hs      = rst_n & w_ar_found & (~r_ar_vld | m_if.arready[0]);
    s_if.arready = '0;
    w_ar_id      = '0;
    w_ar_addr    = '0;
    w_ar_len     = '0;
    w_ar_size    = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      if (w_ar_idx == 2'(i)) begin
        s_if.arready[i] = w_ar_hs;
        w_ar_id         = s_if.arid[i];
        w_ar_addr       = s_if.araddr[i];
        w_ar_len        = s_if.arlen[i];
        w_ar_size       = s_if.arsize[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar_vld  <= 1'b0;
      r_ar_ptr  <= 2'(NUM_MST - 1);
      r_ar_id   <= '0;
      r_ar_addr <= '0;
      r_ar_len  <= '0;
      r_ar_size <= '0;
    end else if (w_ar_hs) begin
      r_ar_vld  <= 1'b1;
      r_ar_ptr  <= w_ar_idx;
      r_ar_id   <= {w_ar_idx, w_ar_id};
      r_ar_addr <= w_ar_addr;
      r_ar_len  <= w_ar_len;
      r_ar_size <= w_ar_size;
    end else if (m_if.arready[0]) begin
      r_ar_vld  <= 1'b0;
    end
  end

  assign m_if.arvalid[0] = r_ar_vld;
  assign m_if.arid[0]    = r_ar_id;
  assign m_if.araddr[0]  = r_ar_addr;
  assign m_if.arlen[0]   = r_ar_len;
  assign m_if.arsize[0]  = r_ar_size;

  // ---------------- B/R routing by ID upper bits ----------------
  logic [1:0] w_b_k, w_r_k;
  logic       w_b_unmapped, w_r_unmapped, r_err;

  assign w_b_k        = m_if.bid[0][S_ID_WIDTH +: 2];
  assign w_r_k        = m_if.rid[0][S_ID_WIDTH +: 2];
  assign w_b_unmapped = int'(w_b_k) >= int'(NUM_MST);
  assign w_r_unmapped = int'(w_r_k) >= int'(NUM_MST);

  always_comb begin
    s_if.bvalid = '0;
    s_if.bid    = '0;
    s_if.bresp  = '0;
    // Responses to a nonexistent master are swallowed.
    m_if.bready[0] = rst_n & w_b_unmapped;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      s_if.bid[i]   = m_if.bid[0][S_ID_WIDTH-1:0];
      s_if.bresp[i] = m_if.bresp[0];
      if (w_b_k == 2'(i)) begin
        s_if.bvalid[i] = rst_n & m_if.bvalid[0];
        m_if.bready[0] = rst_n & s_if.bready[i];
      end
    end
  end

  always_comb begin
    s_if.rvalid = '0;
    s_if.rid    = '0;
    s_if.rdata  = '0;
    s_if.rresp  = '0;
    s_if.rlast  = '0;
    m_if.rready[0] = rst_n & w_r_unmapped;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      s_if.rid[i]   = m_if.rid[0][S_ID_WIDTH-1:0];
      s_if.rdata[i] = m_if.rdata[0];
      s_if.rresp[i] = m_if.rresp[0];
      s_if.rlast[i] = m_if.rlast[0];
      if (w_r_k == 2'(i)) begin
        s_if.rvalid[i] = rst_n & m_if.rvalid[0];
        m_if.rready[0] = rst_n & s_if.rready[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((m_if.bvalid[0] & w_b_unmapped) | (m_if.rvalid[0] & w_r_unmapped)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err_unmapped = r_err;

endmodule

// File: tb/tb_cl_axi_rr_mux.sv
// Directed self-checking bench for cl_axi_rr_mux (3 masters, 32-bit data, FIFO depth 8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_cl_axi_rr_mux;
  localparam int unsigned NM = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] mst_en;
  logic          err_unmapped;
  int            n_asserts = 0;
  int            n_fail = 0;
  int            n_acc;

  cl_axi_rr_mux_if #(.N(NM), .DW(DW), .IW(IW))   s_bus ();
  cl_axi_rr_mux_if #(.N(1),  .DW(DW), .IW(IW+2)) m_bus ();

  cl_axi_rr_mux #(
    .NUM_MST      (NM),
    .DATA_WIDTH   (DW),
    .S_ID_WIDTH   (IW),
    .WR_FIFO_DEPTH(8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_mst_en      (mst_en),
    .o_err_unmapped(err_unmapped),
    .s_if          (s_bus),
    .m_if          (m_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mst_en        = '1;
    s_bus.awid    = '0; s_bus.awaddr = '0; s_bus.awlen = '0; s_bus.awsize = '0;
    s_bus.awvalid = '0;
    s_bus.wdata   = '0; s_bus.wstrb  = '1; s_bus.wlast = '0; s_bus.wvalid = '0;
    s_bus.bready  = '0;
    s_bus.arid    = '0; s_bus.araddr = '0; s_bus.arlen = '0; s_bus.arsize = '0;
    s_bus.arvalid = '0;
    s_bus.rready  = '0;
    m_bus.awready = '0; m_bus.wready = '0; m_bus.arready = '0;
    m_bus.bid     = '0; m_bus.bresp  = '0; m_bus.bvalid = '0;
    m_bus.rid     = '0; m_bus.rdata  = '0; m_bus.rresp = '0; m_bus.rlast = '0;
    m_bus.rvalid  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    // Reset state: requests and responses present, nothing must handshake.
    s_bus.awvalid = 3'b111;
    s_bus.arvalid = 3'b111;
    m_bus.bvalid  = 1'b1;
    m_bus.rvalid  = 1'b1;
    #1;
    check_eq("rst_awready",  s_bus.awready, 3'b000);
    check_eq("rst_arready",  s_bus.arready, 3'b000);
    check_eq("rst_m_awvalid", m_bus.awvalid[0], 1'b0);
    check_eq("rst_m_arvalid", m_bus.arvalid[0], 1'b0);
    check_eq("rst_m_wvalid", m_bus.wvalid[0], 1'b0);
    check_eq("rst_s_bvalid", s_bus.bvalid, 3'b000);
    check_eq("rst_s_rvalid", s_bus.rvalid, 3'b000);
    check_eq("rst_err",      err_unmapped, 1'b0);

    // AW round robin with all masters requesting.
    do_reset();
    m_bus.awready = 1'b1;
    for (int i = 0; i < int'(NM); i++) begin
      s_bus.awid[i]   = 7'(8'h10 + i);
      s_bus.awaddr[i] = 64'(i + 1) << 12;
      s_bus.awlen[i]  = 8'(i);
    end
    s_bus.awvalid = 3'b111;
    for (int g = 0; g < 6; g++) begin
      #1;
      check_eq("aw_rr_grant", s_bus.awready, 3'b001 << (g % 3));
      check_eq("aw_slice_valid", m_bus.awvalid[0], g > 0);
      if (g > 0) check_eq("aw_down_idx", m_bus.awid[0][8:7], (g - 1) % 3);
      @(negedge clk);
    end
    #1;
    check_eq("aw_last_valid", m_bus.awvalid[0], 1'b1);
    check_eq("aw_last_id",    m_bus.awid[0],    9'h112);
    check_eq("aw_last_addr",  m_bus.awaddr[0],  64'h3000);
    check_eq("aw_last_len",   m_bus.awlen[0],   8'd2);

    // W ordering follows AW order even when master 0 offers W first.
    do_reset();
    m_bus.awready   = 1'b1;
    m_bus.wready    = 1'b1;
    s_bus.awid[1]   = 7'h21;
    s_bus.awlen[1]  = 8'd3;
    s_bus.awvalid   = 3'b010;
    s_bus.wdata[0]  = 32'hA0A0_0000;
    s_bus.wlast[0]  = 1'b1;
    s_bus.wvalid[0] = 1'b1;
    #1;
    check_eq("w_aw1_grant",   s_bus.awready, 3'b010);
    check_eq("w_empty_valid", m_bus.wvalid[0], 1'b0);
    check_eq("w_empty_ready", s_bus.wready, 3'b000);
    @(negedge clk);
    s_bus.awvalid  = 3'b001;
    s_bus.awlen[0] = 8'd0;
    #1;
    check_eq("w_aw0_grant",   s_bus.awready, 3'b001);
    check_eq("w_head1_ready", s_bus.wready, 3'b010);
    check_eq("w_head1_valid", m_bus.wvalid[0], 1'b0);
    @(negedge clk);
    s_bus.awvalid   = 3'b000;
    s_bus.wvalid[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_bus.wdata[1] = 32'(32'hB1B1_0000 + b);
      s_bus.wlast[1] = (b == 3);
      #1;
      check_eq("w_m1_valid", m_bus.wvalid[0], 1'b1);
      check_eq("w_m1_data",  m_bus.wdata[0], 32'(32'hB1B1_0000 + b));
      check_eq("w_m1_last",  m_bus.wlast[0], b == 3);
      check_eq("w_m1_ready", s_bus.wready, 3'b010);
      @(negedge clk);
    end
    s_bus.wvalid[1] = 1'b0;
    #1;
    check_eq("w_m0_valid", m_bus.wvalid[0], 1'b1);
    check_eq("w_m0_data",  m_bus.wdata[0], 32'hA0A0_0000);
    check_eq("w_m0_ready", s_bus.wready, 3'b001);
    @(negedge clk);
    s_bus.wvalid[0] = 1'b0;
    #1;
    check_eq("w_drained_valid", m_bus.wvalid[0], 1'b0);

    // FIFO full blocks AW grants until a wlast pops an entry.
    do_reset();
    m_bus.awready = 1'b1;
    s_bus.awvalid = 3'b001;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (s_bus.awready[0]) n_acc++;
      @(negedge clk);
    end
    #1;
    check_eq("fifo_accepts",   n_acc, 8);
    check_eq("fifo_full_rdy",  s_bus.awready, 3'b000);
    s_bus.wvalid[0] = 1'b1;
    s_bus.wlast[0]  = 1'b1;
    m_bus.wready    = 1'b1;
    #1;
    check_eq("fifo_pop_valid", m_bus.wvalid[0], 1'b1);
    check_eq("fifo_pop_rdy",   s_bus.awready, 3'b000);
    @(negedge clk);
    s_bus.wvalid[0] = 1'b0;
    #1;
    check_eq("fifo_freed_rdy", s_bus.awready, 3'b001);

    // B/R routing and unmapped response handling.
    do_reset();
    m_bus.bvalid   = 1'b1;
    m_bus.bid[0]   = 9'h085;
    m_bus.bresp[0] = 2'b10;
    s_bus.bready   = 3'b010;
    #1;
    check_eq("b_route_valid", s_bus.bvalid, 3'b010);
    check_eq("b_route_id",    s_bus.bid[1], 7'h05);
    check_eq("b_route_resp",  s_bus.bresp[1], 2'b10);
    check_eq("b_route_ready", m_bus.bready[0], 1'b1);
    check_eq("b_no_err",      err_unmapped, 1'b0);
    s_bus.bready = 3'b000;
    #1;
    check_eq("b_route_stall", m_bus.bready[0], 1'b0);
    @(negedge clk);
    m_bus.bid[0] = 9'h185;
    #1;
    check_eq("b_unmap_valid", s_bus.bvalid, 3'b000);
    check_eq("b_unmap_ready", m_bus.bready[0], 1'b1);
    @(negedge clk);
    m_bus.bvalid = 1'b0;
    #1;
    check_eq("b_err_set", err_unmapped, 1'b1);
    @(negedge clk);
    m_bus.rvalid   = 1'b1;
    m_bus.rid[0]   = 9'h103;
    m_bus.rdata[0] = 32'hCAFE_0001;
    s_bus.rready   = 3'b100;
    #1;
    check_eq("b_err_sticky",  err_unmapped, 1'b1);
    check_eq("r_route_valid", s_bus.rvalid, 3'b100);
    check_eq("r_route_id",    s_bus.rid[2], 7'h03);
    check_eq("r_route_data",  s_bus.rdata[2], 32'hCAFE_0001);
    check_eq("r_route_ready", m_bus.rready[0], 1'b1);
    s_bus.rready = 3'b000;
    #1;
    check_eq("r_route_stall", m_bus.rready[0], 1'b0);
    m_bus.rvalid = 1'b0;

    // AR arbitration honours the enable mask.
    do_reset();
    mst_en        = 3'b101;
    m_bus.arready = 1'b1;
    s_bus.arvalid = 3'b111;
    for (int g = 0; g < 6; g++) begin
      #1;
      check_eq("ar_masked_grant", s_bus.arready, (g % 2 == 0) ? 3'b001 : 3'b100);
      @(negedge clk);
    end
    #1;
    check_eq("ar_slice_idx", m_bus.arid[0][8:7], 2'd2);
    mst_en = 3'b111;
    #1;
    check_eq("ar_reen_grant0", s_bus.arready, 3'b001);
    @(negedge clk);
    #1;
    check_eq("ar_reen_grant1", s_bus.arready, 3'b010);

    // Reset asserted in the middle of a W burst.
    do_reset();
    m_bus.awready  = 1'b1;
    m_bus.wready   = 1'b1;
    s_bus.awvalid  = 3'b100;
    s_bus.awlen[2] = 8'd3;
    s_bus.arvalid  = 3'b010;
    #1;
    check_eq("mid_aw_grant", s_bus.awready, 3'b100);
    @(negedge clk);
    s_bus.awvalid   = 3'b000;
    s_bus.arvalid   = 3'b000;
    s_bus.wvalid[2] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      check_eq("mid_w_valid", m_bus.wvalid[0], 1'b1);
      @(negedge clk);
    end
    #1;
    check_eq("mid_ar_held", m_bus.arvalid[0], 1'b1);
    #1;
    rst_n = 1'b0;
    s_bus.awvalid = 3'b111;
    #1;
    check_eq("async_wvalid",  m_bus.wvalid[0], 1'b0);
    check_eq("async_wready",  s_bus.wready, 3'b000);
    check_eq("async_arvalid", m_bus.arvalid[0], 1'b0);
    check_eq("async_awready", s_bus.awready, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_grant",  s_bus.awready, 3'b001);
    check_eq("post_rst_wvalid", m_bus.wvalid[0], 1'b0);
    check_eq("post_rst_arvalid", m_bus.arvalid[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/cl_axi_rr_mux.md
CL_AXI_RR_MUX -- requirements
Module: cl_axi_rr_mux

Interface
- REQ-001 SHALL have parameter NUM_MST, default 3, meaning number of AXI4 upstream masters (legal 2..4).
- REQ-002 SHALL have parameter DATA_WIDTH, default 512, meaning data bus width.
- REQ-003 SHALL have parameter S_ID_WIDTH, default 7, meaning upstream ID width; downstream ID width is S_ID_WIDTH+2.
- REQ-004 SHALL have parameter WR_FIFO_DEPTH, default 8, meaning write-order FIFO depth (power of 2, 2..32).
- REQ-005 clk  input  1  sole clock, all logic rising-edge.
- REQ-006 rst_n  input  1  reset, asynchronous, active-low.
- REQ-007 mst_en  input  NUM_MST  per-master enable mask; a cleared bit excludes that master from arbitration.
- REQ-008 s_aw{id,addr,len,size,valid}/s_awready  in/in/in/in/in/out  NUM_MST x {S_ID_WIDTH,64,8,3,1}/NUM_MST  packed upstream AW.
- REQ-009 s_w{data,strb,last,valid}/s_wready  in/out  NUM_MST x {DATA_WIDTH,DATA_WIDTH/8,1,1}/NUM_MST  upstream W.
- REQ-010 s_b{id,resp,valid}/s_bready  out/in  NUM_MST x {S_ID_WIDTH,2,1}/NUM_MST  upstream B.
- REQ-011 s_ar{id,addr,len,size,valid}/s_arready  as AW  upstream AR.
- REQ-012 s_r{id,data,resp,last,valid}/s_rready  out/in  NUM_MST x {S_ID_WIDTH,DATA_WIDTH,2,1,1}/NUM_MST  upstream R.
- REQ-013 m_aw*, m_w*, m_b*, m_ar*, m_r*  mirrored directions  single downstream AXI4 port, IDs S_ID_WIDTH+2 wide.
- REQ-014 err_unmapped  output  1  sticky flag, response carried ID index >= NUM_MST.

Function
- REQ-015 AW and AR each SHALL use an independent round-robin arbiter over requests (s_xvalid[i] & mst_en[i]).
- REQ-016 Round-robin: search starts at index after last winner, wrapping at NUM_MST-1 to 0; pointer updates only on accepted grant.
- REQ-017 Each of AW and AR SHALL have a one-entry output register slice; m_xvalid asserts the cycle after the upstream handshake (latency 1).
- REQ-018 s_xready[i] SHALL be high only for the current winner, and only when the slice is empty or being drained by m_xready that cycle.
- REQ-019 Downstream ID = {2'(winner index), s_xid}; addr/len/size passed unmodified.
- REQ-020 On each AW upstream handshake the winner index SHALL be pushed into the write-order FIFO; AW arbitration SHALL grant nothing while the FIFO is full.
- REQ-021 W path SHALL be combinational, selected by FIFO head: m_w* = s_w*[head], s_wready[head] = m_wready, other s_wready = 0; m_wvalid = 0 when FIFO empty.
- REQ-022 FIFO SHALL pop on m_wvalid & m_wready & m_wlast; simultaneous push and pop at full or empty SHALL keep count consistent (push at full only after pop frees entry same cycle is NOT permitted; full blocks grant).
- REQ-023 W data MAY precede its AW upstream; it SHALL not be forwarded until the FIFO holds its index.
- REQ-024 B and R SHALL route combinationally by ID upper two bits k: s_xvalid[k] = m_xvalid, m_xready = s_xready[k], s_xid[k] = lower S_ID_WIDTH bits, payload broadcast.
- REQ-025 If k >= NUM_MST, m_bready/m_rready SHALL be 1 (response discarded) and err_unmapped SHALL set and hold until reset.
- REQ-026 Clearing mst_en[i] SHALL not abort an in-slice request, queued W burst, or outstanding responses of master i.
- REQ-027 No master with a sustained request SHALL wait more than NUM_MST-1 grants on the same channel.

Reset
- REQ-028 While rst_n low: m_awvalid, m_arvalid, m_wvalid, all s_*ready, all s_bvalid/s_rvalid, err_unmapped = 0; slices empty; FIFO empty; both RR pointers = NUM_MST-1 (master 0 highest priority first).
- REQ-029 Reset assertion mid-burst SHALL discard slice and FIFO contents immediately; no handshake completes in the reset cycle.

Verification
- REQ-030 NUM_MST=3, all masters AW-valid continuously, m_awready=1 -> grant order 0,1,2,0,1,2; m_awid[8:7] matches.
- REQ-031 Master 1 AW len=3 then master 0 AW len=0, master 0 W offered first -> downstream W: four beats of master 1, then master 0; s_wready[0]=0 until master 1 wlast accepted.
- REQ-032 WR_FIFO_DEPTH=8, m_wvalid blocked by no W data, 9 AWs offered -> 8 accepted, 9th s_awready=0 until one wlast popped.
- REQ-033 m_bvalid with bid=9'h085 -> s_bvalid[1]=1, s_bid[1]=7'h05; bid=9'h185 -> m_bready=1, err_unmapped=1 sticky.
- REQ-034 mst_en=3'b101 with all AR valid -> grants alternate 0,2; master 1 never granted; re-enable -> 1 granted within 2 grants.
- REQ-035 rst_n low during 4-beat W burst -> all valids drop asynchronously, FIFO count 0 after release, first new AW granted to master 0.
